// File: rtl/tt_um_mult_sched.sv
// tt_um_mult_sched: command decoder and LOAD/MULT/OUT sequencer for the ternary accelerator (optional load watchdog: MULT_SCHED_WDOG_EN)
module tt_um_mult_sched #(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int WDOG_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ui_input,
  output logic        load_ena,
  input  logic        load_done,
  output logic [6:0]  cfg_param,
  output logic        mac_clr,
  output logic        mac_ena,
  output logic [3:0]  mac_row,
  output logic [7:0]  mac_act,
  output logic        out_valid,
  output logic [2:0]  out_sel,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MULT = 2'd2, OUT = 2'd3} state_t;
`ifdef MULT_SCHED_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [6:0] CFG_RST = {4'(MAX_IN_LEN - 1), 3'(MAX_OUT_LEN - 1)};
  state_t state, state_n;
  logic [3:0] op;
  logic cmd_load, cmd_mult, wdog_to;
  logic wv, wv_n, err_n, load_ena_n, busy_n, mac_clr_n, mac_ena_n, out_valid_n;
  logic [6:0] cfg_n;
  logic [3:0] mac_row_n;
  logic [2:0] out_sel_n;
  logic [WW-1:0] wcnt, wcnt_n;
  assign op       = ui_input[15:12];
  assign cmd_load = state == IDLE && op == 4'hA;
  assign cmd_mult = state == IDLE && op == 4'hB;
  assign wdog_to  = WDOG_EN && state == LOAD && !load_done && wcnt == WW'(WDOG_CYCLES - 1);
  assign mac_act  = ui_input[7:0];
  // state register; reset aborts any phase immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  // phase transitions; MULT/OUT end on the captured shape, not the parameters
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = cmd_load ? LOAD : (cmd_mult && wv) ? MULT : IDLE;
      LOAD: state_n = (load_done || wdog_to) ? IDLE : LOAD;
      MULT: state_n = (mac_ena && mac_row == cfg_param[6:3]) ? OUT : MULT;
      OUT:  state_n = (out_sel == cfg_param[2:0]) ? IDLE : OUT;
    endcase
  end
  // next values of the registered outputs, decoded from the upcoming state so every output is a flop
  always_comb begin
    cfg_n       = cmd_load ? ui_input[11:5] : cfg_param;
    wv_n        = cmd_load ? 1'b0 : (state == LOAD && load_done) ? 1'b1 : wv;
    err_n       = cmd_load ? 1'b0 : cmd_mult ? !wv : wdog_to ? 1'b1 : err;
    load_ena_n  = state_n == LOAD;
    busy_n      = state_n != IDLE;
    mac_clr_n   = state == IDLE && state_n == MULT;
    mac_ena_n   = state == MULT && state_n == MULT;
    mac_row_n   = (mac_ena && state_n == MULT) ? mac_row + 4'd1 : 4'd0;
    out_valid_n = state_n == OUT;
    out_sel_n   = (state == OUT && state_n == OUT) ? out_sel + 3'd1 : 3'd0;
    wcnt_n      = (WDOG_EN && state == LOAD && state_n == LOAD) ? wcnt + WW'(1) : '0;
  end
  // output and bookkeeping registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cfg_param <= CFG_RST;
      wv        <= 1'b0;
      err       <= 1'b0;
      load_ena  <= 1'b0;
      busy      <= 1'b0;
      mac_clr   <= 1'b0;
      mac_ena   <= 1'b0;
      mac_row   <= 4'd0;
      out_valid <= 1'b0;
      out_sel   <= 3'd0;
      wcnt      <= '0;
    end else begin
      cfg_param <= cfg_n;
      wv        <= wv_n;
      err       <= err_n;
      load_ena  <= load_ena_n;
      busy      <= busy_n;
      mac_clr   <= mac_clr_n;
      mac_ena   <= mac_ena_n;
      mac_row   <= mac_row_n;
      out_valid <= out_valid_n;
      out_sel   <= out_sel_n;
      wcnt      <= wcnt_n;
    end
endmodule

// File: tb/tb_tt_um_mult_sched.sv
// tb_tt_um_mult_sched: scoreboard bench for the mult sequencer
module tb_tt_um_mult_sched;
  logic clk = 1'b0, rst = 1'b1, load_done = 1'b0;
  logic [15:0] ui_input = '0;
  logic load_ena, mac_clr, mac_ena, out_valid, busy, err;
  logic [6:0] cfg_param;
  logic [3:0] mac_row;
  logic [7:0] mac_act;
  logic [2:0] out_sel;
  int n_cmp = 0, n_err = 0;
  typedef struct packed {
    logic busy; logic load_ena; logic mac_clr; logic mac_ena; logic [3:0] mac_row;
    logic [7:0] mac_act; logic out_valid; logic [2:0] out_sel; logic err;
  } obs_t;
  obs_t exp_q[$];
  always #5 clk = ~clk;
  tt_um_mult_sched dut (
    .clk(clk), .rst(rst), .ui_input(ui_input), .load_ena(load_ena), .load_done(load_done),
    .cfg_param(cfg_param), .mac_clr(mac_clr), .mac_ena(mac_ena), .mac_row(mac_row),
    .mac_act(mac_act), .out_valid(out_valid), .out_sel(out_sel), .busy(busy), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic obs_t obs();
    return {busy, load_ena, mac_clr, mac_ena, mac_row, mac_act, out_valid, out_sel, err};
  endfunction
  task automatic run_load(input logic [6:0] cfg, input int hold);
    ui_input = {4'hA, cfg, 5'd0};
    for (int c = 1; c <= hold + 1; c++) begin
      @(posedge clk); #1;
      ui_input = '0;
      load_done = 1'b0;
      if (c <= hold) begin
        chk($sformatf("load_ena c%0d", c), 32'(load_ena), 1);
        chk($sformatf("load_busy c%0d", c), 32'(busy), 1);
      end else begin
        chk("load_end", 32'({load_ena, busy, err}), 0);
        chk("load_cfg", 32'(cfg_param), 32'(cfg));
      end
      load_done = c == hold;
    end
  endtask
  task automatic run_mult(input int l, input int m, input bit junk, input logic [7:0] base);
    obs_t e;
    logic [7:0] act;
    for (int c = 1; c <= l + m + 2; c++) begin
      e = '0;
      e.busy      = c <= l + m + 1;
      e.mac_clr   = c == 1;
      e.mac_ena   = c >= 2 && c <= l + 1;
      e.mac_row   = e.mac_ena ? 4'(c - 2) : 4'd0;
      e.mac_act   = e.mac_ena ? base + 8'(c - 2) : 8'd0;
      e.out_valid = c >= l + 2 && c <= l + m + 1;
      e.out_sel   = e.out_valid ? 3'(c - l - 2) : 3'd0;
      exp_q.push_back(e);
    end
    ui_input = 16'hB000;
    for (int c = 1; c <= l + m + 2; c++) begin
      @(posedge clk); #1;
      act = (c >= 2 && c <= l + 1) ? base + 8'(c - 2) : 8'd0;
      ui_input = (junk && c <= l + m + 1) ? {(c % 2 == 1) ? 4'hA : 4'hB, 4'h5, act} : {8'h00, act};
      #1;
      e = exp_q.pop_front();
      chk($sformatf("mult%0dx%0d c%0d", l, m, c), 32'(obs()), 32'(e));
    end
    ui_input = '0;
  endtask
  initial begin
    #500000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 32'(obs()), 0);
    chk("rst_cfg", 32'(cfg_param), 32'h7F);
    rst = 1'b0;
    load_done = 1'b1;
    @(posedge clk); #1;
    load_done = 1'b0;
    chk("stray_done", 32'(obs()), 0);
    ui_input = 16'hB000;
    @(posedge clk); #1;
    ui_input = '0;
    chk("mult_no_weights", 32'({busy, err}), 32'b01);
    ui_input = 16'hC123;
    @(posedge clk); #1;
    ui_input = '0;
    chk("bad_opcode", 32'({busy, cfg_param}), 32'h7F);
    run_load(7'h00, 6);
    run_mult(1, 1, 1'b0, 8'h55);
    run_load(7'h7F, 3);
    run_mult(16, 8, 1'b0, 8'h01);
    run_mult(16, 8, 1'b1, 8'h20);
    chk("cfg_after_junk", 32'(cfg_param), 32'h7F);
    ui_input = 16'hB000;
    @(posedge clk); #1;
    ui_input = '0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_row", 32'({mac_ena, mac_row}), 32'h17);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 32'(obs()), 0);
    chk("async_rst_cfg", 32'(cfg_param), 32'h7F);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    ui_input = 16'hB000;
    @(posedge clk); #1;
    ui_input = '0;
    chk("rst_clears_weights", 32'({busy, err}), 32'b01);
    run_load(7'b0011_010, 4);
    run_mult(4, 3, 1'b0, 8'h40);
`ifdef MULT_SCHED_WDOG_EN
    ui_input = {4'hA, 7'h7F, 5'd0};
    @(posedge clk); #1;
    ui_input = '0;
    n = 0;
    while (load_ena && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    chk("wdog_len", 32'(n), 255);
    chk("wdog_state", 32'({busy, load_ena, err}), 32'b001);
    ui_input = 16'hB000;
    @(posedge clk); #1;
    ui_input = '0;
    chk("wdog_no_weights", 32'({busy, err}), 32'b01);
`else
    n = 0;
`endif
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
